// File: rtl/ahb_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : ahb_result_writer
// Purpose  : AHB-Lite write initiator. Drains a valid/ready word stream of
//            results into DRAM as single-beat-per-word INCR write bursts.
//            Honours HREADY wait states, restarts the burst (NONSEQ) at
//            every 1 KB boundary and after idle gaps, and aborts cleanly on
//            a two-cycle HRESP ERROR response.
// Ports    : HCLK, HRESETn (synchronous, active low)
//            start, base_addr, len_words      - transfer request
//            busy, done, error                - transfer status
//            src_valid, src_data, src_ready   - result word stream
//            HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
//            HREADY, HRESP                    - AHB-Lite master interface
//            wait_cycles (only when RESULT_WRITER_WAITCNT_EN is defined) -
//            number of busy cycles with HREADY low, saturating.
// Options  : RESULT_WRITER_WAITCNT_EN enables the wait-state counter port.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_result_writer #(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic             src_valid,
  input  logic [31:0]      src_data,
  output logic             src_ready,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP
`ifdef RESULT_WRITER_WAITCNT_EN
  ,
  output logic [31:0]      wait_cycles
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [1:0]       state;
  logic [31:0]      addr;
  logic [LEN_W-1:0] addr_left;
  logic             seq_ok;     // previous address phase was an accepted beat
  logic             dp_valid;   // one data phase outstanding
  logic [31:0]      wdata;
  logic             err_resp;
  logic             addr_req;
  logic             accept;

  // An ERROR response in the current data phase cancels any address phase
  // we would otherwise present this cycle.
  assign err_resp = dp_valid & HRESP;
  assign addr_req = (state == ST_RUN) & src_valid & (addr_left != '0) & ~err_resp;
  assign accept   = addr_req & HREADY;

  always_comb begin
    HTRANS = TR_IDLE;
    if (addr_req) begin
      // Burst continues only straight after an accepted beat and never
      // across a 1 KB boundary.
      if (seq_ok && (addr[9:0] != 10'd0)) HTRANS = TR_SEQ;
      else                                HTRANS = TR_NONSEQ;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign src_ready = accept;
  assign HADDR     = addr;
  assign HWDATA    = wdata;
  assign HWRITE    = busy;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b001;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      addr      <= 32'd0;
      addr_left <= '0;
      seq_ok    <= 1'b0;
      dp_valid  <= 1'b0;
      wdata     <= 32'd0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (len_words != '0) begin
              addr      <= {base_addr[31:2], 2'b00};
              addr_left <= len_words;
              seq_ok    <= 1'b0;
              state     <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (err_resp) begin
            if (HREADY) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_ERR;
            end
          end else if (accept) begin
            addr      <= addr + 32'd4;
            addr_left <= addr_left - LEN_W'(1);
            seq_ok    <= 1'b1;
            if (addr_left == LEN_W'(1)) state <= ST_DRAIN;
          end else if (!addr_req) begin
            seq_ok <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (dp_valid && HREADY) begin
            done  <= 1'b1;
            state <= ST_IDLE;
            if (HRESP) error <= 1'b1;
          end else if (err_resp) begin
            state <= ST_ERR;
          end
        end

        ST_ERR: begin
          // Second cycle of the ERROR response ends the transfer.
          if (HREADY) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Data phase pipeline: the accepted word is driven one cycle later and
      // held until the slave completes that data phase.
      if (accept) begin
        dp_valid <= 1'b1;
        wdata    <= src_data;
      end else if (HREADY) begin
        dp_valid <= 1'b0;
      end
    end
  end

`ifdef RESULT_WRITER_WAITCNT_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wait_cycles <= 32'd0;
    end else if ((state == ST_IDLE) && start) begin
      wait_cycles <= 32'd0;
    end else if (busy && !HREADY && (wait_cycles != 32'hFFFF_FFFF)) begin
      wait_cycles <= wait_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_result_writer
// Purpose  : Self-checking bench for ahb_result_writer. A behavioural AHB
//            slave and result source drive the DUT; a transaction-level model
//            predicts addresses, burst kinds, write data, pops and completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_result_writer;

  localparam int LEN_W = 16;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len_words;
  logic             busy, done, error;
  logic             src_valid;
  logic [31:0]      src_data;
  logic             src_ready;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;
  logic             HMASTLOCK;
  logic [31:0]      HWDATA;
  logic             HREADY, HRESP;
`ifdef RESULT_WRITER_WAITCNT_EN
  logic [31:0]      wait_cycles;
`endif

  ahb_result_writer #(.LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
    .len_words(len_words), .busy(busy), .done(done), .error(error),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP)
`ifdef RESULT_WRITER_WAITCNT_EN
    , .wait_cycles(wait_cycles)
`endif
  );

  always #5 HCLK = ~HCLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state, observed by the directed tests after each transfer.
  logic [1:0] kinds[$];
  int         first_act, done_cyc;

  task automatic to_drive();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_kinds(input int n, input logic [7:0] exp);
    logic [7:0] packed_k;
    chk("kinds_count", 64'(kinds.size()), 64'(n));
    if (kinds.size() == n) begin
      packed_k = 8'd0;
      for (int i = 0; i < n; i++) packed_k = {packed_k[5:0], kinds[i]};
      chk("kinds", 64'(packed_k), 64'(exp));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, error, src_ready, HTRANS, HWRITE}), 64'd0);
    chk({tag, "_haddr"}, 64'(HADDR), 64'd0);
    chk({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
`ifdef RESULT_WRITER_WAITCNT_EN
    chk({tag, "_wait"}, 64'(wait_cycles), 64'd0);
`endif
  endtask

  // One transfer, entered and left at the drive point (1 time unit after a
  // rising edge). stall_beat: hold HREADY low 2 cycles in that beat's data
  // phase. gap_beat: source withholds data 3 cycles after that word is
  // popped. err_beat: two-cycle ERROR response in that beat's data phase.
  task automatic run_xfer(input logic [31:0] base, input int len, input int rdy_pct,
                          input int vld_pct, input int stall_beat, input int gap_beat,
                          input int err_beat);
    logic [31:0] q[$];
    logic [31:0] base_w, dp_exp, exp_addr;
    logic [1:0]  prev_trans, exp_kind;
    int idx, accepted, completed, dp_beat, err_phase, stall_left, gap_left, exp_wait;
    bit cur_valid, dp_pend, stall_used, prev_stall, prev_idle;
    bit exp_done_now, exp_done_next, finished, act, acc;

    q.delete();
    for (int i = 0; i < len + 2; i++) q.push_back($urandom);
    kinds.delete();
    base_w = {base[31:2], 2'b00};
    idx = 0; accepted = 0; completed = 0; dp_beat = 0; err_phase = 0;
    stall_left = 0; gap_left = 0; exp_wait = 0;
    cur_valid = 0; dp_pend = 0; stall_used = 0; prev_stall = 0; prev_idle = 1;
    prev_trans = TR_IDLE; exp_done_next = 0; finished = 0;
    first_act = -1; done_cyc = -1;

    start = 1'b1; base_addr = base; len_words = LEN_W'(len);
    src_valid = 1'b0; src_data = $urandom; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    chk("start_busy", 64'(busy), 64'd0);
    to_drive();
    start = 1'b0;

    for (int cyc = 0; !finished; cyc++) begin
      if (cyc >= 3000) begin
        chk("timeout", 64'd1, 64'd0);
        break;
      end
      exp_done_now  = exp_done_next;
      exp_done_next = 0;

      // A start while busy must be ignored.
      start = (cyc == 1 && len >= 4);
      if (start) begin base_addr = $urandom; len_words = LEN_W'(5); end

      if (!cur_valid) begin
        if (gap_left > 0) gap_left--;
        else if (idx < q.size() && ($urandom % 100) < vld_pct) cur_valid = 1;
      end
      src_valid = cur_valid;
      src_data  = cur_valid ? q[idx] : $urandom;

      HRESP = 1'b0;
      if (dp_pend && err_phase == 0 && dp_beat == err_beat) begin
        HRESP = 1'b1; HREADY = 1'b0; err_phase = 1;
      end else if (err_phase == 1) begin
        HRESP = 1'b1; HREADY = 1'b1; err_phase = 2;
      end else if (err_phase == 2) begin
        HREADY = 1'b1;
      end else begin
        if (dp_pend && dp_beat == stall_beat && !stall_used) begin
          stall_used = 1; stall_left = 2;
        end
        if (stall_left > 0) begin
          HREADY = 1'b0; stall_left--;
        end else if (dp_pend) HREADY = (($urandom % 100) < rdy_pct);
        else HREADY = 1'b1;
      end

      @(negedge HCLK);
      chk("done", 64'(done), 64'(exp_done_now));
      if (exp_done_now) begin
        done_cyc = cyc;
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_error", 64'(error), 64'(err_beat != 0));
        chk("end_pops", 64'(idx), 64'(err_beat != 0 ? err_beat : len));
        chk("end_htrans", 64'(HTRANS), 64'(TR_IDLE));
`ifdef RESULT_WRITER_WAITCNT_EN
        chk("end_wait", 64'(wait_cycles), 64'(exp_wait));
`endif
        finished = 1;
      end else begin
        chk("busy", 64'(busy), 64'd1);
        if (cyc == 0) chk("error_cleared", 64'(error), 64'd0);
        act = (HTRANS != TR_IDLE);
        acc = act && HREADY;
        if (err_phase != 0) chk("err_htrans", 64'(HTRANS), 64'(TR_IDLE));
        chk("src_ready", 64'(src_ready), 64'(acc));
        if (act) begin
          if (first_act < 0) first_act = cyc;
          exp_addr = base_w + 32'(accepted) * 32'd4;
          if (prev_stall) exp_kind = prev_trans;
          else if (accepted == 0 || prev_idle || exp_addr[9:0] == 10'd0) exp_kind = TR_NONSEQ;
          else exp_kind = TR_SEQ;
          chk("ctrl", 64'({HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK}), 64'({1'b1, 3'b010, 3'b001, 4'b0011, 1'b0}));
          chk("haddr", 64'(HADDR), 64'(exp_addr));
          chk("htrans", 64'(HTRANS), 64'(exp_kind));
          chk("overrun", 64'(accepted < len), 64'd1);
        end
        if (dp_pend) begin
          chk("hwdata", 64'(HWDATA), 64'(dp_exp));
          if (HREADY) begin
            dp_pend = 0;
            if (err_phase == 0) begin
              completed++;
              if (completed == len) exp_done_next = 1;
            end else exp_done_next = 1;
          end
        end
        if (acc) begin
          kinds.push_back(HTRANS);
          accepted++;
          dp_pend = 1; dp_exp = q[idx]; dp_beat = accepted;
          idx++; cur_valid = 0;
          if (idx == gap_beat) gap_left = 3;
        end
        prev_stall = act && !HREADY;
        prev_trans = HTRANS;
        prev_idle  = !act;
        if (!HREADY) exp_wait++;
      end
      to_drive();
    end

    start = 1'b0; src_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    chk("done_pulse_width", 64'(done), 64'd0);
    to_drive();
  endtask

  initial begin
    int len, eb;
    logic [31:0] b;

    HRESETn = 1'b0; start = 1'b0; base_addr = 32'd0; len_words = '0;
    src_valid = 1'b0; src_data = 32'd0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) to_drive();
    check_reset_outputs("reset");
    HRESETn = 1'b1;
    to_drive();

    // Basic burst: NONSEQ,SEQ,SEQ,SEQ and done five cycles after first beat.
    run_xfer(32'h1000_0000, 4, 100, 100, 0, 0, 0);
    check_kinds(4, {TR_NONSEQ, TR_SEQ, TR_SEQ, TR_SEQ});
    chk("done_latency", 64'(done_cyc - first_act), 64'd5);

    // Two wait states on beat 2.
    run_xfer(32'h2000_0043, 3, 100, 100, 2, 0, 0);
    check_kinds(3, {TR_NONSEQ, TR_SEQ, TR_SEQ});

    // 1 KB boundary crossing.
    run_xfer(32'h1000_03F8, 4, 100, 100, 0, 0, 0);
    check_kinds(4, {TR_NONSEQ, TR_SEQ, TR_NONSEQ, TR_SEQ});

    // Source gap after word 1 restarts the burst.
    run_xfer(32'h3000_0000, 4, 100, 100, 0, 1, 0);
    check_kinds(4, {TR_NONSEQ, TR_NONSEQ, TR_SEQ, TR_SEQ});

    // ERROR on beat 2 of 6: only two words popped.
    run_xfer(32'h4000_0000, 6, 100, 100, 0, 0, 2);
    check_kinds(2, {TR_NONSEQ, TR_SEQ});

    // Zero-length start: done pulse only, and the sticky error clears.
    start = 1'b1; len_words = '0; base_addr = 32'h5000_0000;
    to_drive();
    start = 1'b0;
    @(negedge HCLK);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_state", 64'({busy, error, HTRANS}), 64'd0);
    to_drive();
    @(negedge HCLK);
    chk("len0_done_clear", 64'(done), 64'd0);
    to_drive();

    // Address wrap at 2^32.
    run_xfer(32'hFFFF_FFF8, 4, 80, 90, 0, 0, 0);

    // Randomised transfers.
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 20);
      b = $urandom;
      if (r % 2 == 0) b[9:0] = 10'h3E0 | 10'($urandom_range(0, 31));
      eb = ($urandom % 3 == 0) ? $urandom_range(1, len) : 0;
      run_xfer(b, len, 60, 70, $urandom_range(0, len), $urandom_range(0, len), eb);
    end

    // Reset mid-burst abandons the transfer with no completion pulse.
    start = 1'b1; base_addr = 32'h6000_0000; len_words = LEN_W'(8);
    to_drive();
    start = 1'b0; src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data = $urandom;
      to_drive();
    end
    HRESETn = 1'b0;
    to_drive();
    check_reset_outputs("midreset");
    HRESETn = 1'b1; src_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("midreset_nodone", 64'({done, busy, HTRANS}), 64'd0);
      to_drive();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
